// File: rtl/friscv_pkg.sv
// Shared core package.
// Contents used by the memory arbiter:
//   XLEN, XLEN_BYTES      - data path width in bits and in bytes
//   DMEM_DEPTH_BYTES      - default size of the shared memory in bytes
//   MEM_ARB_STARVE_LIMIT  - default number of denied fetch cycles before fetch wins
//   mem_owner_t           - which port owns the response in flight
package friscv_pkg;

    localparam int XLEN                 = 32;
    localparam int XLEN_BYTES           = XLEN / 8;
    localparam int DMEM_DEPTH_BYTES     = 4096;
    localparam int MEM_ARB_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } mem_owner_t;

endpackage

// File: rtl/friscv_mem_arbiter_if.sv
// Bus bundle between the core's fetch/data ports, the arbiter and the memory.
// Parameter: MEM_DEPTH_BYTES sets the memory word-address width.
// Modports:
//   slave  - arbiter view (takes requests and read data, drives grants,
//            responses and the memory command)
//   master - core/memory view (the opposite directions)
interface friscv_mem_arbiter_if
    import friscv_pkg::*;
#(
    parameter int MEM_DEPTH_BYTES = DMEM_DEPTH_BYTES
);
    localparam int AW = $clog2(MEM_DEPTH_BYTES) - 2;

    // fetch port
    logic                  if_req_i;
    logic [XLEN-1:0]       if_addr_i;
    logic                  if_gnt_o;
    logic                  if_rvalid_o;
    logic [XLEN-1:0]       if_rdata_o;
    logic                  if_err_o;
    // data port
    logic                  dm_req_i;
    logic                  dm_we_i;
    logic [XLEN_BYTES-1:0] dm_be_i;
    logic [XLEN-1:0]       dm_addr_i;
    logic [XLEN-1:0]       dm_wdata_i;
    logic                  dm_gnt_o;
    logic                  dm_rvalid_o;
    logic [XLEN-1:0]       dm_rdata_o;
    logic                  dm_err_o;
    // memory side
    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [XLEN_BYTES-1:0] mem_be_o;
    logic [AW-1:0]         mem_addr_o;
    logic [XLEN-1:0]       mem_wdata_o;
    logic [XLEN-1:0]       mem_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
        input  dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wdata_i,
        output dm_gnt_o, dm_rvalid_o, dm_rdata_o, dm_err_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
        output dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wdata_i,
        input  dm_gnt_o, dm_rvalid_o, dm_rdata_o, dm_err_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i
    );

endinterface

// File: rtl/friscv_mem_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and
// data load/store. Data wins by default; a starvation counter hands the slot
// to fetch after STARVE_LIMIT consecutive denied fetch cycles. Misaligned or
// out-of-range accesses are granted but never reach the memory and answer
// with err = 1, rdata = 0. Responses are routed to the owner one cycle later.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - friscv_mem_arbiter_if.slave (fetch, data and memory signals)
module friscv_mem_arbiter
    import friscv_pkg::*;
#(
    parameter int MEM_DEPTH_BYTES = DMEM_DEPTH_BYTES,
    parameter int STARVE_LIMIT    = MEM_ARB_STARVE_LIMIT
) (
    input  logic                 clk,
    input  logic                 rst,
    friscv_mem_arbiter_if.slave  bus
);

    localparam int              AW    = $clog2(MEM_DEPTH_BYTES) - 2;
    localparam logic [3:0]      LIMIT = 4'(STARVE_LIMIT);
    localparam logic [XLEN-1:0] DEPTH = XLEN'(MEM_DEPTH_BYTES);

    logic [3:0]      starve_cnt_q;
    mem_owner_t      owner_q;
    logic            err_q;

    logic            starved;
    logic            gnt_if;
    logic            gnt_dm;
    logic [XLEN-1:0] sel_addr;
    logic            sel_err;
    mem_owner_t      owner_d;

    // Grant selection and memory command, purely from current requests/state.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned, which would otherwise infer a latch.
        starved         = (starve_cnt_q >= LIMIT);
        gnt_dm          = bus.dm_req_i && (!starved || !bus.if_req_i);
        gnt_if          = bus.if_req_i && !gnt_dm;
        sel_addr        = gnt_dm ? bus.dm_addr_i : bus.if_addr_i;
        sel_err         = (gnt_if || gnt_dm) &&
                          ((sel_addr[1:0] != 2'b00) || (sel_addr >= DEPTH));
        owner_d         = gnt_dm ? OWN_DM : (gnt_if ? OWN_IF : OWN_NONE);

        bus.mem_req_o   = 1'b0;
        bus.mem_we_o    = 1'b0;
        bus.mem_be_o    = '0;
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;
        if ((gnt_if || gnt_dm) && !sel_err) begin
            bus.mem_req_o  = 1'b1;
            bus.mem_addr_o = sel_addr[AW+1:2];
            if (gnt_dm) begin
                bus.mem_we_o    = bus.dm_we_i;
                bus.mem_be_o    = bus.dm_be_i;
                bus.mem_wdata_o = bus.dm_wdata_i;
            end else begin
                bus.mem_be_o    = '1;
            end
        end
    end

    assign bus.if_gnt_o = gnt_if;
    assign bus.dm_gnt_o = gnt_dm;

    // Response routing: only the owner sees rvalid; an erroring access
    // returns zero data instead of whatever the memory holds.
    assign bus.if_rvalid_o = (owner_q == OWN_IF);
    assign bus.if_err_o    = (owner_q == OWN_IF) && err_q;
    assign bus.if_rdata_o  = ((owner_q == OWN_IF) && !err_q) ? bus.mem_rdata_i : '0;
    assign bus.dm_rvalid_o = (owner_q == OWN_DM);
    assign bus.dm_err_o    = (owner_q == OWN_DM) && err_q;
    assign bus.dm_rdata_o  = ((owner_q == OWN_DM) && !err_q) ? bus.mem_rdata_i : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q      <= OWN_NONE;
            err_q        <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            owner_q <= owner_d;
            err_q   <= sel_err;
            // The count only measures an unbroken run of denied fetches.
            if (!bus.if_req_i || gnt_if) begin
                starve_cnt_q <= '0;
            end else if (starve_cnt_q < LIMIT) begin
                starve_cnt_q <= starve_cnt_q + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_friscv_mem_arbiter.sv
module tb_friscv_mem_arbiter;
    import friscv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    friscv_mem_arbiter_if #(.MEM_DEPTH_BYTES(4096)) bus ();

    friscv_mem_arbiter #(
        .MEM_DEPTH_BYTES(4096),
        .STARVE_LIMIT   (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Synchronous single-port memory model, 1024 words.
    logic [31:0] mem [1024];
    logic [31:0] mem_rdata_q = '0;
    assign bus.mem_rdata_i = mem_rdata_q;

    always @(posedge clk) begin
        if (bus.mem_req_o) begin
            mem_rdata_q <= mem[bus.mem_addr_o];
            if (bus.mem_we_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.mem_be_o[b]) mem[bus.mem_addr_o][b*8 +: 8] <= bus.mem_wdata_o[b*8 +: 8];
                end
            end
        end
    end

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_if(input logic req, input logic [31:0] addr);
        bus.if_req_i  = req;
        bus.if_addr_i = addr;
    endtask

    task automatic drive_dm(input logic req, input logic we, input logic [3:0] be,
                            input logic [31:0] addr, input logic [31:0] wdata);
        bus.dm_req_i   = req;
        bus.dm_we_i    = we;
        bus.dm_be_i    = be;
        bus.dm_addr_i  = addr;
        bus.dm_wdata_i = wdata;
    endtask

    // Inputs change on the falling edge; comb outputs sampled 1 ns later.
    task automatic at_negedge();
        @(negedge clk);
        #1;
    endtask

    // Registered responses sampled 1 ns after the rising edge.
    task automatic at_posedge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_if_rvalid"}, 32'(bus.if_rvalid_o), 32'd0);
        check({tag, "_dm_rvalid"}, 32'(bus.dm_rvalid_o), 32'd0);
        check({tag, "_if_rdata"},  bus.if_rdata_o,       32'd0);
        check({tag, "_dm_rdata"},  bus.dm_rdata_o,       32'd0);
        check({tag, "_mem_req"},   32'(bus.mem_req_o),   32'd0);
    endtask

    // Both ports request continuously; fetch must win only on every 5th cycle.
    task automatic contention(input string tag, input int cycles);
        drive_if(1'b1, 32'h10);
        drive_dm(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
        for (int i = 0; i < cycles; i++) begin
            #1;
            check($sformatf("%s_dm_gnt%0d", tag, i), 32'(bus.dm_gnt_o), (i == 4) ? 32'd0 : 32'd1);
            check($sformatf("%s_if_gnt%0d", tag, i), 32'(bus.if_gnt_o), (i == 4) ? 32'd1 : 32'd0);
            at_posedge();
            check($sformatf("%s_dm_rv%0d", tag, i), 32'(bus.dm_rvalid_o), (i == 4) ? 32'd0 : 32'd1);
            check($sformatf("%s_if_rv%0d", tag, i), 32'(bus.if_rvalid_o), (i == 4) ? 32'd1 : 32'd0);
            check($sformatf("%s_dm_rd%0d", tag, i), bus.dm_rdata_o, (i == 4) ? 32'h0 : 32'h0BADF00D);
            check($sformatf("%s_if_rd%0d", tag, i), bus.if_rdata_o, (i == 4) ? 32'hDEADBEEF : 32'h0);
            @(negedge clk);
        end
        drive_if(1'b0, 32'h0);
        drive_dm(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        for (int w = 0; w < 1024; w++) mem[w] = 32'h0;
        mem[0] = 32'h0BADF00D;
        mem[4] = 32'hDEADBEEF;

        drive_if(1'b0, 32'h0);
        drive_dm(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_quiet("reset");
        check("reset_if_gnt", 32'(bus.if_gnt_o), 32'd0);
        check("reset_dm_gnt", 32'(bus.dm_gnt_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single fetch from 0x10 (word 4)
        at_negedge();
        drive_if(1'b1, 32'h10);
        #1;
        check("fetch_gnt",      32'(bus.if_gnt_o),   32'd1);
        check("fetch_dm_gnt",   32'(bus.dm_gnt_o),   32'd0);
        check("fetch_mem_req",  32'(bus.mem_req_o),  32'd1);
        check("fetch_mem_addr", 32'(bus.mem_addr_o), 32'd4);
        check("fetch_mem_we",   32'(bus.mem_we_o),   32'd0);
        check("fetch_mem_be",   32'(bus.mem_be_o),   32'hF);
        at_posedge();
        check("fetch_rvalid",    32'(bus.if_rvalid_o), 32'd1);
        check("fetch_rdata",     bus.if_rdata_o,       32'hDEADBEEF);
        check("fetch_err",       32'(bus.if_err_o),    32'd0);
        check("fetch_dm_rvalid", 32'(bus.dm_rvalid_o), 32'd0);

        // No request: no memory access, no response next cycle
        @(negedge clk);
        drive_if(1'b0, 32'h0);
        #1;
        check("idle_mem_req", 32'(bus.mem_req_o), 32'd0);
        at_posedge();
        check_quiet("idle");

        // Contention from counter = 0: DM, DM, DM, DM, IF, DM
        @(negedge clk);
        contention("cont", 6);
        at_posedge();
        check_quiet("cont_end");

        // Store 0x12345678, be = 0011, to 0x20 (word 8)
        @(negedge clk);
        drive_dm(1'b1, 1'b1, 4'b0011, 32'h20, 32'h12345678);
        #1;
        check("st_gnt",       32'(bus.dm_gnt_o),    32'd1);
        check("st_mem_req",   32'(bus.mem_req_o),   32'd1);
        check("st_mem_we",    32'(bus.mem_we_o),    32'd1);
        check("st_mem_be",    32'(bus.mem_be_o),    32'h3);
        check("st_mem_addr",  32'(bus.mem_addr_o),  32'd8);
        check("st_mem_wdata", bus.mem_wdata_o,      32'h12345678);
        at_posedge();
        check("st_ack",       32'(bus.dm_rvalid_o), 32'd1);
        check("st_err",       32'(bus.dm_err_o),    32'd0);
        check("st_if_rvalid", 32'(bus.if_rvalid_o), 32'd0);

        // Load back 0x20
        @(negedge clk);
        drive_dm(1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
        #1;
        check("ld_gnt",    32'(bus.dm_gnt_o), 32'd1);
        check("ld_mem_we", 32'(bus.mem_we_o), 32'd0);
        at_posedge();
        check("ld_rvalid", 32'(bus.dm_rvalid_o), 32'd1);
        check("ld_rdata",  bus.dm_rdata_o,       32'h00005678);
        check("ld_err",    32'(bus.dm_err_o),    32'd0);

        // Misaligned load 0x21
        @(negedge clk);
        drive_dm(1'b1, 1'b0, 4'h0, 32'h21, 32'h0);
        #1;
        check("mis_gnt",     32'(bus.dm_gnt_o),  32'd1);
        check("mis_mem_req", 32'(bus.mem_req_o), 32'd0);
        at_posedge();
        check("mis_rvalid", 32'(bus.dm_rvalid_o), 32'd1);
        check("mis_err",    32'(bus.dm_err_o),    32'd1);
        check("mis_rdata",  bus.dm_rdata_o,       32'h0);

        // Out-of-range load 0x1000
        @(negedge clk);
        drive_dm(1'b1, 1'b0, 4'h0, 32'h1000, 32'h0);
        #1;
        check("oor_gnt",     32'(bus.dm_gnt_o),  32'd1);
        check("oor_mem_req", 32'(bus.mem_req_o), 32'd0);
        at_posedge();
        check("oor_rvalid", 32'(bus.dm_rvalid_o), 32'd1);
        check("oor_err",    32'(bus.dm_err_o),    32'd1);
        check("oor_rdata",  bus.dm_rdata_o,       32'h0);

        // Misaligned fetch 0x12 reports on the fetch port only
        @(negedge clk);
        drive_dm(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive_if(1'b1, 32'h12);
        #1;
        check("ifmis_gnt",     32'(bus.if_gnt_o),  32'd1);
        check("ifmis_mem_req", 32'(bus.mem_req_o), 32'd0);
        at_posedge();
        check("ifmis_rvalid",    32'(bus.if_rvalid_o), 32'd1);
        check("ifmis_err",       32'(bus.if_err_o),    32'd1);
        check("ifmis_rdata",     bus.if_rdata_o,       32'h0);
        check("ifmis_dm_rvalid", 32'(bus.dm_rvalid_o), 32'd0);
        check("ifmis_dm_err",    32'(bus.dm_err_o),    32'd0);

        // Reset mid-access: build up the starvation count, then reset while
        // a data response is pending.
        @(negedge clk);
        drive_if(1'b1, 32'h10);
        drive_dm(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_pre_rvalid", 32'(bus.dm_rvalid_o), 32'd1);
        rst = 1'b1;
        drive_if(1'b0, 32'h0);
        drive_dm(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        check_quiet("rst_mid");
        check("rst_mid_if_err", 32'(bus.if_err_o), 32'd0);
        check("rst_mid_dm_err", 32'(bus.dm_err_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        at_posedge();
        check_quiet("rst_after");

        // Counter restarted at 0: again four DM grants before IF
        @(negedge clk);
        contention("post_rst", 5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "timeout");
    end

endmodule
